wired_fetch_queue: RTL and testbench
====================================

Name: wired_fetch_queue

Overview:
- Decoupling FIFO between wired_pcgen and the instruction-cache request stage.
- Accepts one fetch packet per cycle from pcgen: aligned PC, 2-slot mask and per-slot prediction metadata.
- Buffers packets and presents them in order to the icache stage, tagging each with a wrapping queue index for later back-reference.
- Flushes completely on a redirect from the branch-correction path.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- PRED_W, 64, packed width of one slot's prediction record (bpu_predict_t).
- IDX_W, $clog2(DEPTH)+1, width of the queue index, including the wrap bit.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  redirect from the correction path; discard all contents
- in_valid_i  in  1  packet offered by pcgen
- in_ready_o  out  1  queue can accept; drives pcgen p_ready_i
- in_pc_i  in  32  fetch PC; bits [2:0] are ignored and stored as 0
- in_mask_i  in  2  slot valid mask
- in_pred_i  in  2*PRED_W  slot predictions; slot 0 in the low half
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  icache stage accepts the head entry
- out_pc_o  out  32  head PC
- out_mask_o  out  2  head mask
- out_pred_o  out  2*PRED_W  head predictions
- out_idx_o  out  IDX_W  index of the head entry (read pointer, including wrap bit)
- count_o  out  IDX_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clk edge):
  - read and write pointers = 0, count = 0.
  - out_valid_o=0, in_ready_o=1, out_idx_o=0, count_o=0.
  - Storage contents are don't-care; out_pc/mask/pred are don't-care while out_valid_o=0.
- Reset has priority over flush, push and pop in the same cycle.
- Push:
  - Occurs when in_valid_i && in_ready_o && !flush_i.
  - Writes entry[wptr] = {in_pc_i[31:3],3'b000, in_mask_i, in_pred_i}; wptr increments modulo 2*DEPTH.
- Pop:
  - Occurs when out_valid_o && out_ready_i && !flush_i.
  - rptr increments modulo 2*DEPTH.
- Pointers are IDX_W bits wide; the entry address is ptr[IDX_W-2:0].
  - empty = (wptr == rptr); full = MSBs differ and the low bits are equal.
- in_ready_o = !full. It depends only on registered state, with no combinational path from out_ready_i or flush_i.
- Push while full is impossible because ready is low. Pop-then-push in the same cycle at full is not supported; the push waits one cycle.
- Simultaneous push and pop when not full or empty: both happen, count is unchanged.
- out_valid_o = !empty, from registers.
- Data outputs are a combinational read of entry[rptr]. There is no input-to-output bypass: minimum latency from push to out_valid_o is 1 cycle.
- out_idx_o = rptr.
- count_o = wptr - rptr (mod 2*DEPTH), which evaluates 0..DEPTH.
- Flush:
  - rptr <= wptr, so the queue becomes empty next cycle and indices keep advancing monotonically.
  - A push offered in the same cycle is dropped; pcgen is simultaneously redirected, so that packet is stale.
  - A pop in the same cycle does not occur.
  - Flush has priority over push and pop.
- Output holding: head data and out_idx_o remain stable while out_valid_o && !out_ready_i, unless flush_i is asserted.
- Mask values: mask 2'b00 is stored and forwarded unchanged; the queue does not filter it.

Test Plan:
- Reset then idle:
  - assert rst 2 cycles -> out_valid_o=0, in_ready_o=1, count_o=0, out_idx_o=0.
- Single pass:
  - push pc=32'h1c000004, mask=2'b10 -> next cycle out_valid_o=1, out_pc_o=32'h1c000000, out_mask_o=2'b10, out_idx_o=0.
  - pop -> out_valid_o=0, count_o=0.
- Fill/backpressure (DEPTH=4, out_ready_i=0):
  - 4 pushes of pc 0x1c000000..0x1c000018 -> count_o=4, in_ready_o=0.
  - 5th offer is not accepted.
  - release out_ready_i -> packets exit in order with idx 0,1,2,3.
- Streaming:
  - in_valid_i=1, out_ready_i=1 for 20 cycles -> count_o stays 1 after the first cycle.
  - out_idx_o sequence 0..7 then wraps to 0, with no dropped or duplicated PCs.
- Flush mid-stream:
  - 3 entries queued (idx 5,6,7), flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0.
  - next push appears with out_idx_o=0 (= old wptr 8 mod 8).
- Reset during traffic:
  - rst=1 while full with flush_i=1 and out_ready_i=1 -> next cycle all pointers 0, count_o=0, in_ready_o=1.

Source files
------------

// File: rtl/wired_fetch_queue.sv
// Decoupling FIFO between pcgen and the icache request stage. Each entry holds
// an aligned fetch PC, a 2-slot mask and per-slot predictions; the head is tagged by the read pointer.
module wired_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PRED_W = 64,
    parameter int IDX_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [31:0]         in_pc_i,
    input  logic [1:0]          in_mask_i,
    input  logic [2*PRED_W-1:0] in_pred_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [31:0]         out_pc_o,
    output logic [1:0]          out_mask_o,
    output logic [2*PRED_W-1:0] out_pred_o,
    output logic [IDX_W-1:0]    out_idx_o,
    output logic [IDX_W-1:0]    count_o
);

    localparam int AW = IDX_W - 1;

    logic [IDX_W-1:0]    wptr;
    logic [IDX_W-1:0]    rptr;
    logic [31:3]         pc_mem   [DEPTH];
    logic [1:0]          mask_mem [DEPTH];
    logic [2*PRED_W-1:0] pred_mem [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    assign waddr = wptr[AW-1:0];
    assign raddr = rptr[AW-1:0];
    assign empty = (wptr == rptr);
    assign full  = (wptr[IDX_W-1] != rptr[IDX_W-1]) && (waddr == raddr);

    assign push = in_valid_i && !full && !flush_i;
    assign pop  = !empty && out_ready_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            // Empty by catching up the read side, so indices keep advancing.
            rptr <= wptr;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[waddr]   <= in_pc_i[31:3];
            mask_mem[waddr] <= in_mask_i;
            pred_mem[waddr] <= in_pred_i;
        end
    end

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign out_pc_o    = {pc_mem[raddr], 3'b000};
    assign out_mask_o  = mask_mem[raddr];
    assign out_pred_o  = pred_mem[raddr];
    assign out_idx_o   = rptr;
    assign count_o     = wptr - rptr;

endmodule

// File: tb/tb_wired_fetch_queue.sv
// Bench for wired_fetch_queue: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_wired_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int PRED_W = 64;
    localparam int IDX_W  = 3;
    localparam int NIDX   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                flush_i = 1'b0;
    logic                in_valid_i = 1'b0;
    logic                in_ready_o;
    logic [31:0]         in_pc_i = '0;
    logic [1:0]          in_mask_i = '0;
    logic [2*PRED_W-1:0] in_pred_i = '0;
    logic                out_valid_o;
    logic                out_ready_i = 1'b0;
    logic [31:0]         out_pc_o;
    logic [1:0]          out_mask_o;
    logic [2*PRED_W-1:0] out_pred_o;
    logic [IDX_W-1:0]    out_idx_o;
    logic [IDX_W-1:0]    count_o;

    wired_fetch_queue #(.DEPTH(DEPTH), .PRED_W(PRED_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
        .in_mask_i(in_mask_i), .in_pred_i(in_pred_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
        .out_mask_o(out_mask_o), .out_pred_o(out_pred_o),
        .out_idx_o(out_idx_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]  pc;
        logic [1:0]   mask;
        logic [127:0] pred;
    } pkt_t;

    pkt_t        mq[$];
    int unsigned m_head = 0;

    typedef struct {
        logic        r, f, iv, ordy;
        logic [31:0] pc;
        logic [1:0]  mask;
        logic        e_valid, e_ready;
        int unsigned e_count, e_idx;
        logic [31:0] e_pc;
        logic [1:0]  e_mask;
    } vec_t;

    function automatic logic [127:0] pred_of(input logic [31:0] pc);
        return {~pc, pc * 32'd3, pc ^ 32'h5a5a_5a5a, pc + 32'd1};
    endfunction

    function automatic vec_t mk(input logic r, f, iv, input logic [31:0] pc,
                                input logic [1:0] m, input logic ordy,
                                input logic ev, er, input int unsigned ec, ei,
                                input logic [31:0] epc, input logic [1:0] em);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.pc = pc; v.mask = m; v.ordy = ordy;
        v.e_valid = ev; v.e_ready = er; v.e_count = ec; v.e_idx = ei;
        v.e_pc = epc; v.e_mask = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", out_valid_o, mq.size() > 0);
        chk("ready", in_ready_o, mq.size() < DEPTH);
        chk("count", count_o, mq.size());
        chk("idx", out_idx_o, m_head);
        if (mq.size() > 0) begin
            chk("pc", out_pc_o, mq[0].pc);
            chk("mask", out_mask_o, mq[0].mask);
            chk("pred", out_pred_o, mq[0].pred);
        end
    endtask

    // Drive one cycle, advance the model across the edge, then check just after it.
    task automatic step(input logic r, f, iv, input logic [31:0] pc, input logic [1:0] m,
                        input logic [127:0] pr, input logic ordy);
        bit   do_push, do_pop;
        pkt_t p;
        rst = r; flush_i = f; in_valid_i = iv; in_pc_i = pc; in_mask_i = m;
        in_pred_i = pr; out_ready_i = ordy;
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_head = 0;
        end else if (f) begin
            m_head = (m_head + mq.size()) % NIDX;
            mq.delete();
        end else begin
            if (do_pop) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % NIDX;
            end
            if (do_push) begin
                p.pc = {pc[31:3], 3'b000};
                p.mask = m;
                p.pred = pr;
                mq.push_back(p);
            end
        end
        check_model();
    endtask

    task automatic idle_step(input logic r, input logic ordy);
        step(r, 1'b0, 1'b0, 32'h0, 2'b00, '0, ordy);
    endtask

    task automatic push_step(input logic [31:0] pc, input logic ordy);
        step(1'b0, 1'b0, 1'b1, pc, 2'(pc[4:3]), pred_of(pc), ordy);
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = mk(1,0,0, 32'h0,        2'b00, 0, 0,1, 0,0, 32'h0,        2'b00);
        tbl[1]  = mk(1,0,0, 32'h0,        2'b00, 0, 0,1, 0,0, 32'h0,        2'b00);
        tbl[2]  = mk(0,0,0, 32'h0,        2'b00, 1, 0,1, 0,0, 32'h0,        2'b00);
        tbl[3]  = mk(0,0,1, 32'h1c000004, 2'b10, 0, 1,1, 1,0, 32'h1c000000, 2'b10);
        tbl[4]  = mk(0,0,0, 32'h0,        2'b00, 1, 0,1, 0,1, 32'h0,        2'b00);
        tbl[5]  = mk(1,0,0, 32'h0,        2'b00, 0, 0,1, 0,0, 32'h0,        2'b00);
        tbl[6]  = mk(0,0,1, 32'h1c000000, 2'b01, 0, 1,1, 1,0, 32'h1c000000, 2'b01);
        tbl[7]  = mk(0,0,1, 32'h1c000008, 2'b11, 0, 1,1, 2,0, 32'h1c000000, 2'b01);
        tbl[8]  = mk(0,0,1, 32'h1c000010, 2'b00, 0, 1,1, 3,0, 32'h1c000000, 2'b01);
        tbl[9]  = mk(0,0,1, 32'h1c000018, 2'b10, 0, 1,0, 4,0, 32'h1c000000, 2'b01);
        tbl[10] = mk(0,0,1, 32'h1c000020, 2'b11, 0, 1,0, 4,0, 32'h1c000000, 2'b01);
        tbl[11] = mk(0,0,0, 32'h0,        2'b00, 1, 1,1, 3,1, 32'h1c000008, 2'b11);
        tbl[12] = mk(0,0,0, 32'h0,        2'b00, 1, 1,1, 2,2, 32'h1c000010, 2'b00);
        tbl[13] = mk(0,0,0, 32'h0,        2'b00, 1, 1,1, 1,3, 32'h1c000018, 2'b10);
        tbl[14] = mk(0,0,0, 32'h0,        2'b00, 1, 0,1, 0,4, 32'h0,        2'b00);
        tbl[15] = mk(0,0,0, 32'h0,        2'b00, 0, 0,1, 0,4, 32'h0,        2'b00);

        #2;
        // Directed table.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].pc, tbl[i].mask,
                 pred_of({tbl[i].pc[31:3], 3'b000}), tbl[i].ordy);
            chk($sformatf("tbl%0d_valid", i), out_valid_o, tbl[i].e_valid);
            chk($sformatf("tbl%0d_ready", i), in_ready_o, tbl[i].e_ready);
            chk($sformatf("tbl%0d_count", i), count_o, tbl[i].e_count);
            chk($sformatf("tbl%0d_idx", i), out_idx_o, tbl[i].e_idx);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), out_pc_o, tbl[i].e_pc);
                chk($sformatf("tbl%0d_mask", i), out_mask_o, tbl[i].e_mask);
                chk($sformatf("tbl%0d_pred", i), out_pred_o, pred_of(tbl[i].e_pc));
            end
        end

        // Pop-then-push at full: the push must wait a cycle.
        idle_step(1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) push_step(32'h2000_0000 + 32'(i * 8), 1'b0);
        push_step(32'h2000_0100, 1'b1);
        chk("fullpp_count", count_o, DEPTH - 1);
        push_step(32'h2000_0100, 1'b0);
        chk("fullpp_count2", count_o, DEPTH);

        // Streaming: one in, one out every cycle, indices wrap.
        idle_step(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            push_step(32'h1c00_0000 + 32'((k - 1) * 8), 1'b1);
            chk("stream_count", count_o, 1);
            chk("stream_idx", out_idx_o, (k - 1) % NIDX);
            chk("stream_pc", out_pc_o, 32'h1c00_0000 + 32'((k - 1) * 8));
        end

        // Flush mid-stream with a push offered in the same cycle.
        idle_step(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            push_step(32'h3000_0000 + 32'(k * 8), 1'b0);
            idle_step(1'b0, 1'b1);
        end
        for (int k = 0; k < 3; k++) push_step(32'h3100_0000 + 32'(k * 8), 1'b0);
        chk("flush_pre_count", count_o, 3);
        chk("flush_pre_idx", out_idx_o, 5);
        step(1'b0, 1'b1, 1'b1, 32'h3200_0000, 2'b11, pred_of(32'h3200_0000), 1'b1);
        chk("flush_count", count_o, 0);
        chk("flush_valid", out_valid_o, 1'b0);
        push_step(32'h3300_0008, 1'b0);
        chk("flush_next_idx", out_idx_o, 0);
        chk("flush_next_pc", out_pc_o, 32'h3300_0008);

        // Reset beats flush, push and pop.
        for (int k = 0; k < DEPTH; k++) push_step(32'h4000_0000 + 32'(k * 8), 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h4100_0000, 2'b01, '0, 1'b1);
        chk("rst_count", count_o, 0);
        chk("rst_ready", in_ready_o, 1'b1);
        chk("rst_idx", out_idx_o, 0);
        chk("rst_valid", out_valid_o, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(63) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0,
                 $urandom, 2'($urandom), {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
